fetch_unit: RTL

//  Instruction fetch stage; feeds decode_unit. Issues in-order reads to instruction memory
//  and buffers returned 16-bit instructions in a DEPTH-entry FIFO. Presents the FIFO head
//  to decode. On a taken branch it flushes the FIFO, kills in-flight reads and redirects the PC.

---
 rtl/fetch_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding decode.
// Issues in-order word reads to instruction memory, buffers the returned
// 16-bit instructions in a small FIFO and presents the head to decode.
// A taken branch flushes the FIFO, marks every read still in flight as
// stale and restarts fetching at the branch target.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        is_branch_taken,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {
    ST_HOLD,
    ST_RUN
  } run_state_t;

  run_state_t state, state_nxt;

  logic [15:0]   fetch_pc;
  logic [15:0]   resp_pc;
  logic [15:0]   last_pc;
  logic [15:0]   data_mem [DEPTH];
  logic [15:0]   pc_mem   [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] kill_cnt;
  logic [CW:0]   occupancy;
  logic          credit;
  logic          fire;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Hold off requests for one edge after reset release, then run freely
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_HOLD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next run state plus request, push and pop decisions for this cycle
  always_comb begin
    state_nxt       = state;
    imem_req        = 1'b0;
    imem_addr       = fetch_pc;
    occupancy       = {1'b0, count} + {1'b0, outstanding};
    credit          = occupancy < (CW + 1)'(DEPTH);
    instr_valid     = (count != '0);
    instr           = 16'h0000;
    instr_pc        = last_pc;
    if (state == ST_HOLD) begin
      state_nxt = ST_RUN;
    end
    if (state == ST_RUN && credit && !is_branch_taken) begin
      imem_req = 1'b1;
    end
    if (instr_valid) begin
      instr    = data_mem[rd_ptr];
      instr_pc = pc_mem[rd_ptr];
    end
    fire            = imem_req && imem_gnt;
    push            = imem_rvalid && (kill_cnt == '0) && !is_branch_taken;
    pop             = instr_valid && !stall && !is_branch_taken;
    outstanding_nxt = outstanding + CW'(fire) - CW'(imem_rvalid);
  end

  // FIFO storage; entries are only read while count says they are live
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= resp_pc;
    end
  end

  // Fetch pointer, read tracking and FIFO bookkeeping; a branch overrides all
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      last_pc     <= 16'h0000;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      kill_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      last_pc     <= instr_pc;
      if (is_branch_taken) begin
        // Every read still in flight after this edge belongs to the old stream
        fetch_pc <= branch_target;
        resp_pc  <= branch_target;
        kill_cnt <= outstanding_nxt;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (fire) begin
          fetch_pc <= fetch_pc + 16'h0001;
        end
        if (imem_rvalid && kill_cnt != '0) begin
          kill_cnt <= kill_cnt - 1'b1;
        end
        if (push) begin
          wr_ptr  <= ptr_inc(wr_ptr);
          resp_pc <= resp_pc + 16'h0001;
        end
        if (pop) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule
